// File: rtl/serial_code_pkg.sv
// serial_code_pkg
//   Definitions shared by the serial code transmitter and the receiver/detector
//   blocks that consume its stream: the frame state encoding and line levels.
//   No ports.
package serial_code_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } serial_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// bit_timer
//   Counts clocks within one serial bit and flags the last clock of the bit.
//   Ports:
//     clock     in   system clock, rising edge
//     reset_n   in   asynchronous active-low reset
//     clear     in   synchronous clear (frame start), overrides en
//     en        in   count while a frame is in progress
//     bit_done  out  high during the last clock of each bit
module bit_timer #(
    parameter int BIT_CYCLES = 5
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic bit_done
);

    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign bit_done = en && (cnt == LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            // Wrap at each bit boundary so every bit gets exactly BIT_CYCLES clocks.
            if (cnt == LAST) cnt <= '0;
            else             cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/serial_code_tx.sv
// serial_code_tx
//   Framed serial transmitter: accepts a DATA_W-bit word on valid/ready and
//   sends start(0), data LSB first, [even parity], stop(1), each bit held for
//   BIT_CYCLES clocks. Line output is registered and idles high.
//   Optional feature: define SERIAL_CODE_TX_PARITY_EN to insert an even parity
//   bit between the last data bit and the stop bit.
//   Ports:
//     clock    in   system clock, rising edge
//     reset_n  in   asynchronous active-low reset
//     data     in   word to send, sampled only on handshake
//     valid    in   data is valid
//     ready    out  idle, can accept a word
//     a        out  serial line
//     busy     out  frame in progress
module serial_code_tx
    import serial_code_pkg::*;
#(
    parameter int DATA_W     = 3,
    parameter int BIT_CYCLES = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic              a,
    output logic              busy
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    serial_state_t     state;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_nxt;
    logic [BW-1:0]     bit_cnt;
    logic              bit_done;
    logic              accept;
`ifdef SERIAL_CODE_TX_PARITY_EN
    logic              parity_bit;
`endif

    assign ready     = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = valid && ready;
    assign shift_nxt = shift_reg >> 1;

    bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (accept),
        .en       (busy),
        .bit_done (bit_done)
    );

    // The line level is computed together with the state transition so that
    // it changes on the same edge as the state and comes straight from a flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            a         <= LINE_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
`ifdef SERIAL_CODE_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    a <= LINE_IDLE;
                    if (accept) begin
                        shift_reg <= data;
                        bit_cnt   <= '0;
`ifdef SERIAL_CODE_TX_PARITY_EN
                        parity_bit <= ^data;
`endif
                        state     <= START;
                        a         <= START_BIT;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state <= DATA;
                        a     <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_CODE_TX_PARITY_EN
                            state <= PARITY;
                            a     <= parity_bit;
`else
                            state <= STOP;
                            a     <= STOP_BIT;
`endif
                        end else begin
                            bit_cnt   <= bit_cnt + BW'(1);
                            shift_reg <= shift_nxt;
                            a         <= shift_nxt[0];
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state <= STOP;
                        a     <= STOP_BIT;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        state <= IDLE;
                        a     <= LINE_IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    a     <= LINE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_code_tx.sv
// tb_serial_code_tx
//   Directed bench for serial_code_tx with DATA_W=3. Expected line sequences
//   are written per serial bit (index 0 = start bit) and held for BC clocks.
module tb_serial_code_tx;

`ifdef SERIAL_CODE_TX_PARITY_EN
    localparam int BC = 1;
    localparam int NB = 6;
`else
    localparam int BC = 2;
    localparam int NB = 5;
`endif

    logic       clock;
    logic       reset_n;
    logic [2:0] data;
    logic       valid;
    logic       ready;
    logic       a;
    logic       busy;

    int n_cmp;
    int n_err;

    serial_code_tx #(
        .DATA_W     (3),
        .BIT_CYCLES (BC)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .data    (data),
        .valid   (valid),
        .ready   (ready),
        .a       (a),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] d;
        logic [5:0] seq;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (ready !== 1'b1 && k < 100) begin
            @(posedge clock); #1;
            k++;
        end
        chk("ready_wait", {31'd0, ready}, 32'd1);
    endtask

    // Called 1 time unit after the handshake edge; checks the whole frame and
    // the first idle clock after it.
    task automatic check_frame(input string name, input logic [5:0] seq);
        for (int i = 0; i < NB * BC; i++) begin
            chk({name, "_a"}, {31'd0, a}, {31'd0, seq[i / BC]});
            chk({name, "_busy"}, {31'd0, busy}, 32'd1);
            @(posedge clock); #1;
        end
        chk({name, "_end_ready"}, {31'd0, ready}, 32'd1);
        chk({name, "_end_a"}, {31'd0, a}, 32'd1);
        chk({name, "_end_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic send(input logic [2:0] d);
        wait_ready();
        @(negedge clock);
        data  = d;
        valid = 1'b1;
        @(posedge clock); #1;
        valid = 1'b0;
        data  = ~d;   // must be ignored mid-frame
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        data    = 3'b000;
        valid   = 1'b0;
        reset_n = 1'b0;

`ifdef SERIAL_CODE_TX_PARITY_EN
        tbl[0] = '{3'b101, 6'b101010};
        tbl[1] = '{3'b000, 6'b100000};
        tbl[2] = '{3'b111, 6'b111110};
        tbl[3] = '{3'b110, 6'b101100};
        tbl[4] = '{3'b011, 6'b100110};
`else
        tbl[0] = '{3'b101, 6'b011010};
        tbl[1] = '{3'b000, 6'b010000};
        tbl[2] = '{3'b111, 6'b011110};
        tbl[3] = '{3'b110, 6'b011100};
        tbl[4] = '{3'b011, 6'b010110};
`endif

        // Reset held for 3 clocks
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("rst_a", {31'd0, a}, 32'd1);
            chk("rst_ready", {31'd0, ready}, 32'd1);
            chk("rst_busy", {31'd0, busy}, 32'd0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk("idle_a", {31'd0, a}, 32'd1);

        // Table-driven single frames
        for (int v = 0; v < 5; v++) begin
            send(tbl[v].d);
            check_frame($sformatf("vec%0d", v), tbl[v].seq);
        end

        // Back-to-back with valid held: second start exactly one idle clock later
        wait_ready();
        @(negedge clock);
        data  = 3'b011;
        valid = 1'b1;
        @(posedge clock); #1;
        data  = 3'b100;
        check_frame("b2b_first", tbl[4].seq);
        @(posedge clock); #1;
        valid = 1'b0;
        data  = 3'b000;
`ifdef SERIAL_CODE_TX_PARITY_EN
        check_frame("b2b_second", 6'b111000);
`else
        check_frame("b2b_second", 6'b011000);
`endif

        // Reset during data bit 1 (data bit 1 of 3'b101 is 0)
        send(3'b101);
        for (int i = 0; i < 2 * BC; i++) begin
            @(posedge clock); #1;
        end
        chk("pre_rst_a", {31'd0, a}, 32'd0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("async_rst_a", {31'd0, a}, 32'd1);
        chk("async_rst_ready", {31'd0, ready}, 32'd1);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            chk("in_rst_a", {31'd0, a}, 32'd1);
        end
        // valid already high when reset releases: accepted on the first edge
        @(negedge clock);
        data    = 3'b010;
        valid   = 1'b1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        valid = 1'b0;
`ifdef SERIAL_CODE_TX_PARITY_EN
        check_frame("post_rst", 6'b110100);
`else
        check_frame("post_rst", 6'b010100);
`endif

        // No spontaneous activity with valid low
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("quiet_a", {31'd0, a}, 32'd1);
            chk("quiet_ready", {31'd0, ready}, 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
